// File: rtl/bcd_number_accumulator_if.sv
// Digit-stream / result bundle between the BCD converter, the accumulator
// and the command logic that consumes completed numbers.
interface bcd_number_accumulator_if #(
  parameter int VAL_W = 17
);
  logic             clr;
  logic             dig_done;
  logic [3:0]       dig_bcd;
  logic [VAL_W-1:0] value;
  logic             num_valid;
  logic [3:0]       ndigits;
  logic             err;

  modport master (
    output clr, dig_done, dig_bcd,
    input  value, num_valid, ndigits, err
  );

  modport slave (
    input  clr, dig_done, dig_bcd,
    output value, num_valid, ndigits, err
  );
endinterface

// File: rtl/bcd_number_accumulator.sv
// Assembles a stream of BCD digit codes, terminated by code 10, into an
// unsigned binary number; invalid codes and overlong numbers are rejected.
module bcd_number_accumulator #(
  parameter int MAX_DIGITS = 5,
  parameter int VAL_W      = 17
) (
  input logic                    clk,
  input logic                    rst_n,
  bcd_number_accumulator_if.slave bus
);

  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_ERR = 1'b1
  } state_t;

  localparam logic [3:0] MAX_ND   = 4'(MAX_DIGITS);
  localparam logic [3:0] CODE_TRM = 4'd10;

  state_t           r_state;
  logic             r_prev;
  logic [VAL_W-1:0] r_acc;
  logic [VAL_W-1:0] r_value;
  logic             r_num_valid;
  logic [3:0]       r_ndigits;
  logic             r_err;

  logic             w_ev;
  logic             w_is_digit;
  logic             w_is_term;
  logic [VAL_W-1:0] w_acc_next;

  assign w_ev       = bus.dig_done & ~r_prev;
  assign w_is_digit = (bus.dig_bcd <= 4'd9);
  assign w_is_term  = (bus.dig_bcd == CODE_TRM);
  // acc*10 + code, built from shifts; digit count guarantees no wrap
  assign w_acc_next = (r_acc << 3) + (r_acc << 1) + {{(VAL_W-4){1'b0}}, bus.dig_bcd};

  // Edge detect, accumulation FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ACC;
      r_prev      <= 1'b0;
      r_acc       <= '0;
      r_value     <= '0;
      r_num_valid <= 1'b0;
      r_ndigits   <= 4'd0;
      r_err       <= 1'b0;
    end else begin
      r_prev      <= bus.dig_done;
      r_num_valid <= 1'b0;
      if (bus.clr) begin
        r_state   <= ST_ACC;
        r_acc     <= '0;
        r_ndigits <= 4'd0;
        r_err     <= 1'b0;
      end else if (w_ev) begin
        case (r_state)
          ST_ACC: begin
            if (w_is_digit) begin
              if (r_ndigits < MAX_ND) begin
                r_acc     <= w_acc_next;
                r_ndigits <= r_ndigits + 4'd1;
              end else begin
                r_state <= ST_ERR;
                r_err   <= 1'b1;
              end
            end else if (w_is_term) begin
              if (r_ndigits != 4'd0) begin
                r_value     <= r_acc;
                r_num_valid <= 1'b1;
                r_acc       <= '0;
                r_ndigits   <= 4'd0;
              end else begin
                r_state <= ST_ERR;
                r_err   <= 1'b1;
              end
            end else begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end
          end
          ST_ERR: begin
            // Discard everything until the terminator resynchronises us
            if (w_is_term) begin
              r_state   <= ST_ACC;
              r_err     <= 1'b0;
              r_acc     <= '0;
              r_ndigits <= 4'd0;
            end else begin
              r_state <= ST_ERR;
            end
          end
          default: begin
            r_state   <= ST_ACC;
            r_acc     <= '0;
            r_ndigits <= 4'd0;
            r_err     <= 1'b0;
          end
        endcase
      end else begin
        r_state <= r_state;
      end
    end
  end

  assign bus.value     = r_value;
  assign bus.num_valid = r_num_valid;
  assign bus.ndigits   = r_ndigits;
  assign bus.err       = r_err;

endmodule
